// File: rtl/gor_pkg.sv
// gor_pkg: shared types and defaults for the OR-gate input debouncer.
//   deb_state_t    : per-channel debounce FSM encoding (2 bits)
//   GOR_STABLE_CNT : default number of differing samples before the output flips
//   GOR_CNT_W      : default debounce counter width
package gor_pkg;

  localparam int unsigned GOR_STABLE_CNT = 50000;
  localparam int unsigned GOR_CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } deb_state_t;

endpackage : gor_pkg

// File: rtl/gor_debounce_ch.sv
// gor_debounce_ch: one input channel -- 2-flop synchroniser, debounce counter
// and FSM, plus an optional registered rising-edge pulse.
// Optional feature macro: GOR_EDGE_DETECT_EN (adds the rise port).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   raw  : raw asynchronous level
//   dout : debounced, registered level
//   rise : one-cycle pulse in the first cycle dout reads 1 (macro builds only)
module gor_debounce_ch
  import gor_pkg::*;
#(
  parameter int unsigned STABLE_CNT = GOR_STABLE_CNT,
  parameter int unsigned CNT_W      = GOR_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic dout
`ifdef GOR_EDGE_DETECT_EN
  ,
  output logic rise
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single required sample the output flips straight from the stable state.
  localparam bit SINGLE = (STABLE_CNT == 1);

  logic             s1_q;
  logic             s2_q;
  deb_state_t       state_q;
  deb_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dout_d;

  // Two-flop synchroniser; only s2_q is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // FSM state, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      dout    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout    <= dout_d;
    end
  end

  // Next-state logic; any return of s2 to the output value clears the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout;
    case (state_q)
      ST_LOW: begin
        if (s2_q) begin
          if (SINGLE) begin
            state_d = ST_HIGH;
            dout_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = CHK_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_HIGH: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          dout_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          if (SINGLE) begin
            state_d = ST_LOW;
            dout_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = CHK_LOW;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_LOW: begin
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          dout_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
  end

`ifdef GOR_EDGE_DETECT_EN
  // Rise pulse is registered alongside dout, so it is high exactly when dout first reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
    end else begin
      rise <= dout_d & ~dout;
    end
  end
`endif

endmodule : gor_debounce_ch

// File: rtl/gor_in_debounce.sv
// gor_in_debounce: conditions the two raw inputs of the OR gate into clean,
// registered levels a and b. Channels are fully independent.
// Optional feature macro: GOR_EDGE_DETECT_EN (adds a_rise / b_rise).
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   a_raw, b_raw   : raw asynchronous levels
//   a, b           : debounced levels feeding the gate
//   a_rise, b_rise : one-cycle rising-edge pulses (macro builds only)
module gor_in_debounce
  import gor_pkg::*;
#(
  parameter int unsigned STABLE_CNT = GOR_STABLE_CNT,
  parameter int unsigned CNT_W      = GOR_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b
`ifdef GOR_EDGE_DETECT_EN
  ,
  output logic a_rise,
  output logic b_rise
`endif
);

  gor_debounce_ch #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) u_ch_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (a_raw),
    .dout (a)
`ifdef GOR_EDGE_DETECT_EN
    ,
    .rise (a_rise)
`endif
  );

  gor_debounce_ch #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) u_ch_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (b_raw),
    .dout (b)
`ifdef GOR_EDGE_DETECT_EN
    ,
    .rise (b_rise)
`endif
  );

endmodule : gor_in_debounce

// File: tb/tb_gor_in_debounce.sv
// tb_gor_in_debounce: directed, table-driven bench for gor_in_debounce
// with STABLE_CNT=4, CNT_W=3. Each table row holds inputs for n edges and
// the outputs expected after every one of those edges.
module tb_gor_in_debounce;

  localparam int unsigned STABLE_CNT = 4;
  localparam int unsigned CNT_W      = 3;

  logic clk = 1'b0;
  logic rst;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
`ifdef GOR_EDGE_DETECT_EN
  logic a_rise;
  logic b_rise;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gor_in_debounce #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a      (a),
    .b      (b)
`ifdef GOR_EDGE_DETECT_EN
    ,
    .a_rise (a_rise),
    .b_rise (b_rise)
`endif
  );

  // exp_cnt / exp_st: channel A counter and state after the last edge of the row, -1 = skip
  typedef struct {
    logic rst;
    logic a_raw;
    logic b_raw;
    int   n;
    logic exp_a;
    logic exp_b;
    logic exp_ar;
    logic exp_br;
    int   exp_cnt;
    int   exp_st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic ar, logic br, int n, logic ea, logic eb,
                              logic ear, logic ebr, int ec, int es);
    vec_t v;
    v.rst = r; v.a_raw = ar; v.b_raw = br; v.n = n;
    v.exp_a = ea; v.exp_b = eb; v.exp_ar = ear; v.exp_br = ebr;
    v.exp_cnt = ec; v.exp_st = es;
    tbl.push_back(v);
  endfunction

  function automatic void chk(string name, int idx, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(int idx, logic ea, logic eb, logic ear, logic ebr);
    chk("a", idx, int'(a), int'(ea));
    chk("b", idx, int'(b), int'(eb));
`ifdef GOR_EDGE_DETECT_EN
    chk("a_rise", idx, int'(a_rise), int'(ear));
    chk("b_rise", idx, int'(b_rise), int'(ebr));
`endif
  endtask

  task automatic check_int(int idx, int ec, int es);
    if (ec >= 0) chk("cnt_a", idx, int'(dut.u_ch_a.cnt_q), ec);
    if (es >= 0) chk("state_a", idx, int'(dut.u_ch_a.state_q), es);
  endtask

  initial begin
    // State codes: 0 ST_LOW, 1 CHK_HIGH, 2 ST_HIGH, 3 CHK_LOW
    // Reset with raw inputs high, then both rise on the 6th edge after release
    add(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 5, 0, 0, 0, 0, 3, 1);
    add(0, 1, 1, 1, 1, 1, 1, 1, 0, 2);
    add(0, 1, 1, 1, 1, 1, 0, 0, -1, -1);
    add(0, 0, 0, 5, 1, 1, 0, 0, 3, 3);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2, 0, 0, 0, 0, -1, -1);
    // Clean step on A only
    add(0, 1, 0, 5, 0, 0, 0, 0, -1, -1);
    add(0, 1, 0, 1, 1, 0, 1, 0, 0, 2);
    add(0, 1, 0, 2, 1, 0, 0, 0, -1, -1);
    add(0, 0, 0, 5, 1, 0, 0, 0, 3, 3);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2, 0, 0, 0, 0, -1, -1);
    // Glitch: three raw-high cycles are rejected, counter returns to 0
    add(0, 1, 0, 3, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 2, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 3, 1);
    add(0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    // Bounce 1,0,1,0 then hold 1
    add(0, 1, 0, 1, 0, 0, 0, 0, -1, -1);
    add(0, 0, 0, 1, 0, 0, 0, 0, -1, -1);
    add(0, 1, 0, 1, 0, 0, 0, 0, -1, -1);
    add(0, 0, 0, 1, 0, 0, 0, 0, -1, -1);
    add(0, 1, 0, 5, 0, 0, 0, 0, 3, 1);
    add(0, 1, 0, 1, 1, 0, 1, 0, 0, 2);
    add(0, 1, 0, 2, 1, 0, 0, 0, -1, -1);
    // Simultaneous opposite transitions, both directions
    add(0, 0, 1, 5, 1, 0, 0, 0, -1, -1);
    add(0, 0, 1, 1, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 2, 0, 1, 0, 0, -1, -1);
    add(0, 1, 0, 5, 0, 1, 0, 0, -1, -1);
    add(0, 1, 0, 1, 1, 0, 1, 0, 0, 2);
    add(0, 1, 0, 1, 1, 0, 0, 0, -1, -1);
    add(0, 0, 0, 5, 1, 0, 0, 0, -1, -1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2, 0, 0, 0, 0, -1, -1);

    rst   = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst   = tbl[i].rst;
      a_raw = tbl[i].a_raw;
      b_raw = tbl[i].b_raw;
      for (int c = 0; c < tbl[i].n; c++) begin
        tick();
        check_outs(i, tbl[i].exp_a, tbl[i].exp_b, tbl[i].exp_ar, tbl[i].exp_br);
      end
      check_int(i, tbl[i].exp_cnt, tbl[i].exp_st);
    end

    // Mid-count reset: A reaches cnt=2 in CHK_HIGH, reset discards it
    rst   = 1'b0;
    a_raw = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_outs(100, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_int(100, 2, 1);
    rst = 1'b1;
    tick();
    check_outs(101, 1'b0, 1'b0, 1'b0, 1'b0);
    check_int(101, 0, 0);
    chk("s2_a", 101, int'(dut.u_ch_a.s2_q), 0);
    // Full latency again after release, raw still high
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_outs(102, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs(103, 1'b1, 1'b0, 1'b1, 1'b0);
    check_int(103, 0, 2);
    tick();
    check_outs(104, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_gor_in_debounce
